// File: rtl/gtx_seq_pkg.sv
// Shared types and helpers for the multi-channel GTX test/reset sequencer.
package gtx_seq_pkg;

  localparam int unsigned LLC_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    PULSE     = 2'd2,
    READY     = 2'd3
  } seq_state_e;

  // Countdown load value: all-ones over the rate-dependent counter width.
  function automatic int unsigned load_val(input logic rate, input int unsigned ctr_w,
                                           input int unsigned fast_shift);
    int unsigned w;
    w = rate ? (ctr_w - fast_shift) : ctr_w;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/gtx_test_seq_if.sv
// Per-channel lock/rate/restart inputs and GTXTEST outputs of the sequencer.
// LOCK_LOSS_CNT exists only when GTXSEQ_STATUS_EN is defined.
interface gtx_test_seq_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0] PLLLKDET;
  logic [NCH-1:0] TX_RATE;
  logic           INIT;
  logic [NCH-1:0] CH_INIT;
  logic [NCH-1:0] GTXTEST_DONE;
  logic [NCH-1:0] GTXTEST_BIT1;
  logic [NCH-1:0] CH_BUSY;
  logic           ALL_DONE;
`ifdef GTXSEQ_STATUS_EN
  logic [gtx_seq_pkg::LLC_W*NCH-1:0] LOCK_LOSS_CNT;
`endif

  modport master (
    output PLLLKDET, TX_RATE, INIT, CH_INIT,
`ifdef GTXSEQ_STATUS_EN
    input  LOCK_LOSS_CNT,
`endif
    input  GTXTEST_DONE, GTXTEST_BIT1, CH_BUSY, ALL_DONE
  );

  modport slave (
    input  PLLLKDET, TX_RATE, INIT, CH_INIT,
`ifdef GTXSEQ_STATUS_EN
    output LOCK_LOSS_CNT,
`endif
    output GTXTEST_DONE, GTXTEST_BIT1, CH_BUSY, ALL_DONE
  );
endinterface

// File: rtl/gtx_test_seq_ch.sv
// One sequencer channel: lock synchroniser, WAIT_LOCK/COUNT/PULSE/READY FSM,
// rate-aware countdown driving GTXTEST[1] and TESTDONE. GTXSEQ_STATUS_EN adds a lock-loss counter.
module gtx_test_seq_ch
  import gtx_seq_pkg::*;
#(
  parameter int unsigned CTR_W       = 11,
  parameter int unsigned FAST_SHIFT  = 4,
  parameter int unsigned DONE_LEN    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic plllkdet,
  input  logic tx_rate,
  input  logic init,
  input  logic ch_init,
  output logic done,
  output logic bit1,
  output logic busy,
  output logic ready_c
`ifdef GTXSEQ_STATUS_EN
  ,
  output logic [LLC_W-1:0] lock_loss_cnt
`endif
);

  localparam int unsigned FW   = CTR_W - FAST_SHIFT;
  localparam int unsigned PC_W = (DONE_LEN > 1) ? $clog2(DONE_LEN) : 1;
  localparam logic [CTR_W-1:0] LOAD_N = CTR_W'(load_val(1'b0, CTR_W, FAST_SHIFT));
  localparam logic [CTR_W-1:0] LOAD_F = CTR_W'(load_val(1'b1, CTR_W, FAST_SHIFT));

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  seq_state_e             state_q, state_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d, ctr_dec, ld_val;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic                   rate_q, rate_d;
  logic                   bit1_q, bit1_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   lock_sync, restart;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], plllkdet};
  assign lock_sync = sync_q[SYNC_STAGES-1];
  assign restart   = !lock_sync || init || ch_init;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    pc_d    = pc_q;
    rate_d  = rate_q;
    bit1_d  = bit1_q;
    done_d  = 1'b0;
    ld_val  = tx_rate ? LOAD_F : LOAD_N;
    ctr_dec = (ctr_q == '0) ? '0 : ctr_q - CTR_W'(1);
    if (restart) begin
      state_d = WAIT_LOCK;
      ctr_d   = LOAD_N;
      bit1_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rate_d  = tx_rate;
          ctr_d   = ld_val;
          state_d = COUNT;
        end
        COUNT: begin
          if (tx_rate != rate_q) begin
            // Rate flipped mid-count: restart the countdown at the new rate.
            rate_d = tx_rate;
            ctr_d  = ld_val;
            bit1_d = 1'b0;
          end else begin
            ctr_d = ctr_dec;
            if (!rate_q && !ctr_dec[CTR_W-1]) bit1_d = ctr_dec[CTR_W-3];
            if (rate_q && !ctr_dec[FW-1])     bit1_d = ctr_dec[FW-2];
            if (ctr_dec == '0) begin
              state_d = PULSE;
              pc_d    = PC_W'(DONE_LEN - 1);
              done_d  = 1'b1;
            end
          end
        end
        PULSE: begin
          if (pc_q == '0) begin
            state_d = READY;
          end else begin
            pc_d   = pc_q - PC_W'(1);
            done_d = 1'b1;
          end
        end
        READY:   ;
        default: state_d = WAIT_LOCK;
      endcase
    end
    busy_d = (state_d != READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= WAIT_LOCK;
      ctr_q   <= LOAD_N;
      pc_q    <= '0;
      rate_q  <= 1'b0;
      bit1_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ctr_q   <= ctr_d;
      pc_q    <= pc_d;
      rate_q  <= rate_d;
      bit1_q  <= bit1_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done    = done_q;
  assign bit1    = bit1_q;
  assign busy    = busy_q;
  assign ready_c = (state_q == READY);

`ifdef GTXSEQ_STATUS_EN
  logic [LLC_W-1:0] llc_q, llc_d;

  // Saturating count of cycles that see lock lost outside WAIT_LOCK.
  always_comb begin
    llc_d = llc_q;
    if (!lock_sync && (state_q != WAIT_LOCK) && (llc_q != '1)) llc_d = llc_q + LLC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) llc_q <= '0;
    else        llc_q <= llc_d;
  end

  assign lock_loss_cnt = llc_q;
`endif

endmodule

// File: rtl/gtx_test_seq.sv
// Multi-channel GTX test/reset sequencer top: reset-release synchroniser, channel array, ALL_DONE.
// Optional per-channel LOCK_LOSS_CNT when GTXSEQ_STATUS_EN is defined.
module gtx_test_seq
  import gtx_seq_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CTR_W       = 11,
  parameter int unsigned FAST_SHIFT  = 4,
  parameter int unsigned DONE_LEN    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  gtx_test_seq_if.slave bus
);

  logic [1:0]     rst_sync_q, rst_sync_d;
  logic           rst_n_int;
  logic [NCH-1:0] ready_c;
  logic           all_done_q, all_done_d;

  // Asserts asynchronously, releases two edges after RST_N rises.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gtx_test_seq_ch #(
      .CTR_W       (CTR_W),
      .FAST_SHIFT  (FAST_SHIFT),
      .DONE_LEN    (DONE_LEN),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (rst_n_int),
      .plllkdet (bus.PLLLKDET[i]),
      .tx_rate  (bus.TX_RATE[i]),
      .init     (bus.INIT),
      .ch_init  (bus.CH_INIT[i]),
      .done     (bus.GTXTEST_DONE[i]),
      .bit1     (bus.GTXTEST_BIT1[i]),
      .busy     (bus.CH_BUSY[i]),
      .ready_c  (ready_c[i])
`ifdef GTXSEQ_STATUS_EN
      ,
      .lock_loss_cnt (bus.LOCK_LOSS_CNT[i*LLC_W +: LLC_W])
`endif
    );
  end

  assign all_done_d = &ready_c;

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) all_done_q <= 1'b0;
    else            all_done_q <= all_done_d;
  end

  assign bus.ALL_DONE = all_done_q;

endmodule

// File: tb/tb_gtx_test_seq.sv
// Directed self-checking bench for gtx_test_seq (default parameters).
module tb_gtx_test_seq;
  import gtx_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gtx_test_seq_if #(.NCH(4)) bif ();

  gtx_test_seq #(.NCH(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc, d_first, d_last, d_cnt, b_nr, b_nf, b_hi, ad_first;
  int b_rise[4];
  int b_fall[4];
  logic prev_b1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_rec();
    cyc = 0; d_first = -1; d_last = -1; d_cnt = 0;
    b_nr = 0; b_nf = 0; b_hi = 0; ad_first = -1;
    for (int i = 0; i < 4; i++) begin b_rise[i] = -1; b_fall[i] = -1; end
    prev_b1 = bif.GTXTEST_BIT1[0];
  endtask

  // Advance one cycle and record channel-0 DONE/BIT1 activity and ALL_DONE.
  task automatic tick();
    logic b;
    @(posedge clk); #1;
    cyc++;
    if (bif.GTXTEST_DONE[0]) begin
      if (d_first < 0) d_first = cyc;
      d_last = cyc;
      d_cnt++;
    end
    b = bif.GTXTEST_BIT1[0];
    if (b) b_hi++;
    if (b && !prev_b1 && b_nr < 4) begin b_rise[b_nr] = cyc; b_nr++; end
    if (!b && prev_b1 && b_nf < 4) begin b_fall[b_nf] = cyc; b_nf++; end
    prev_b1 = b;
    if (bif.ALL_DONE && ad_first < 0) ad_first = cyc;
  endtask

  task automatic drop_all();
    bif.PLLLKDET = '0;
    repeat (6) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0;
    bif.PLLLKDET = '0; bif.TX_RATE = '0; bif.INIT = 1'b0; bif.CH_INIT = '0;
    repeat (3) @(negedge clk);
    check("rst_done",  int'(bif.GTXTEST_DONE), 0);
    check("rst_bit1",  int'(bif.GTXTEST_BIT1), 0);
    check("rst_busy",  int'(bif.CH_BUSY), 0);
    check("rst_alldn", int'(bif.ALL_DONE), 0);
`ifdef GTXSEQ_STATUS_EN
    check("rst_llc", int'(bif.LOCK_LOSS_CNT), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("post_rst_busy", int'(bif.CH_BUSY), 4'hF);

    // Normal rate on ch0.
    clr_rec();
    bif.PLLLKDET[0] = 1'b1;
    repeat (2060) tick();
    check("n_done_first", d_first, 2050);
    check("n_done_last",  d_last, 2053);
    check("n_done_cnt",   d_cnt, 4);
    check("n_b1_rise0",   b_rise[0], 1027);
    check("n_b1_fall0",   b_fall[0], 1283);
    check("n_b1_rise1",   b_rise[1], 1539);
    check("n_b1_fall1",   b_fall[1], 1795);
    check("n_b1_hi",      b_hi, 512);
    check("n_busy",       int'(bif.CH_BUSY), 4'hE);
    check("n_alldone",    ad_first, -1);

    // Fast rate on ch0.
    drop_all();
    bif.TX_RATE[0] = 1'b1;
    clr_rec();
    bif.PLLLKDET[0] = 1'b1;
    repeat (140) tick();
    check("f_done_first", d_first, 130);
    check("f_done_last",  d_last, 133);
    check("f_b1_rise0",   b_rise[0], 67);
    check("f_b1_fall0",   b_fall[0], 99);
    check("f_b1_hi",      b_hi, 32);

    // Rate change 0->1 at cycle 500 of COUNT (COUNT starts at cycle 3).
    drop_all();
    bif.TX_RATE[0] = 1'b0;
    clr_rec();
    bif.PLLLKDET[0] = 1'b1;
    repeat (640) begin
      tick();
      if (cyc == 503) begin
        check("rc_b1_before", int'(bif.GTXTEST_BIT1[0]), 0);
        bif.TX_RATE[0] = 1'b1;
      end
    end
    check("rc_done_first", d_first, 631);
    check("rc_done_cnt",   d_cnt, 4);
    check("rc_b1_rise0",   b_rise[0], 568);
    check("rc_b1_fall0",   b_fall[0], 600);

    // Lock lost for 3 cycles mid-COUNT (fast rate).
    drop_all();
    clr_rec();
    bif.PLLLKDET[0] = 1'b1;
    repeat (200) begin
      tick();
      if (cyc == 50) bif.PLLLKDET[0] = 1'b0;
      if (cyc == 53) bif.PLLLKDET[0] = 1'b1;
    end
    check("ll_done_first", d_first, 183);
    check("ll_done_cnt",   d_cnt, 4);
    check("ll_busy",       int'(bif.CH_BUSY[0]), 0);
`ifdef GTXSEQ_STATUS_EN
    check("ll_llc0", int'(bif.LOCK_LOSS_CNT[7:0]), 4);
    check("ll_llc1", int'(bif.LOCK_LOSS_CNT[15:8]), 0);
`endif

    // INIT on the cycle the count reaches zero.
    drop_all();
    clr_rec();
    bif.PLLLKDET[0] = 1'b1;
    repeat (270) begin
      tick();
      if (cyc == 129) bif.INIT = 1'b1;
      if (cyc == 130) begin
        bif.INIT = 1'b0;
        check("in_busy_130", int'(bif.CH_BUSY[0]), 1);
      end
    end
    check("in_done_first", d_first, 258);
    check("in_alldone",    ad_first, -1);

    // All channels locking at staggered times (fast rate).
    drop_all();
    bif.TX_RATE = 4'hF;
    clr_rec();
    bif.PLLLKDET[0] = 1'b1;
    repeat (170) begin
      tick();
      if (cyc == 5)  bif.PLLLKDET[1] = 1'b1;
      if (cyc == 10) bif.PLLLKDET[2] = 1'b1;
      if (cyc == 20) bif.PLLLKDET[3] = 1'b1;
    end
    check("st_done0_first", d_first, 130);
    check("st_alldone",     ad_first, 155);
    check("st_busy",        int'(bif.CH_BUSY), 0);

    // Asynchronous reset in the middle of a normal-rate count.
    drop_all();
    bif.TX_RATE = 4'h0;
    clr_rec();
    bif.PLLLKDET = 4'hF;
    repeat (1100) tick();
    check("ar_bit1_pre", int'(bif.GTXTEST_BIT1), 4'hF);
    check("ar_busy_pre", int'(bif.CH_BUSY), 4'hF);
    rst_n = 1'b0;
    #2;
    check("ar_done", int'(bif.GTXTEST_DONE), 0);
    check("ar_bit1", int'(bif.GTXTEST_BIT1), 0);
    check("ar_busy", int'(bif.CH_BUSY), 0);
    check("ar_alldone", int'(bif.ALL_DONE), 0);
`ifdef GTXSEQ_STATUS_EN
    check("ar_llc", int'(bif.LOCK_LOSS_CNT), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
